clock_adjust_ctrl: RTL and testbench

CLOCK_ADJUST_CTRL -- requirements
Module: clock_adjust_ctrl

---
 rtl/clock_adjust_ctrl_pkg.sv | 46 ++++
 rtl/clock_adjust_ctrl_key.sv | 41 ++++
 rtl/clock_adjust_ctrl.sv | 98 +++++++++
 tb/tb_clock_adjust_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_adjust_ctrl_pkg.sv
// Shared definitions for the adjustable clock: FSM states, adjust-field codes,
// BCD limits and the small helpers that step the digit pairs.
package clock_adjust_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    ADJ_HOUR = 2'd1,
    ADJ_MIN  = 2'd2,
    ADJ_WEEK = 2'd3
  } AdjState_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_WEEK = 2'd3;

  // Digit pairs are kept as packed BCD {high, low}.
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [3:0] WEEK_MIN = 4'd1;
  localparam logic [3:0] WEEK_MAX = 4'd7;

  function automatic logic [7:0] bcdInc(input logic [7:0] val, input logic [7:0] maxVal);
    if (val == maxVal)
      return 8'h00;
    else if (val[3:0] == 4'd9)
      return {val[7:4] + 4'd1, 4'd0};
    else
      return {val[7:4], val[3:0] + 4'd1};
  endfunction

  function automatic logic [3:0] weekInc(input logic [3:0] w);
    return (w == WEEK_MAX) ? WEEK_MIN : w + 4'd1;
  endfunction

  function automatic logic [1:0] fieldOf(input AdjState_t s);
    case (s)
      ADJ_HOUR: return FIELD_HOUR;
      ADJ_MIN:  return FIELD_MIN;
      ADJ_WEEK: return FIELD_WEEK;
      default:  return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_adjust_ctrl_key.sv
// key_debounce: two-flop synchronizer plus counter debouncer for one active-low key;
// Press is a registered one-cycle pulse on each debounced 1->0 transition.
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic KeyRaw_n,
  output logic Press
);

  logic sync1, sync2, level;
  logic [19:0] cnt;
  logic expire;

  // The synchronized level has disagreed with the debounced one long enough.
  assign expire = (sync2 != level) && (cnt == DEBOUNCE_CYCLES - 20'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= 20'd0;
      Press <= 1'b0;
    end else begin
      sync1 <= KeyRaw_n;
      sync2 <= sync1;
      Press <= expire && level;
      if (sync2 == level) begin
        cnt <= 20'd0;
      end else if (expire) begin
        level <= sync2;
        cnt   <= 20'd0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/clock_adjust_ctrl.sv
// Time-of-day clock with week counter and a mode/inc key adjust FSM
// (RUN -> ADJ_HOUR -> ADJ_MIN -> ADJ_WEEK -> RUN).
module clock_adjust_ctrl
  import clock_adjust_ctrl_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Tick1Hz,
  input  logic       KeyMode_n,
  input  logic       KeyInc_n,
  output logic [3:0] SecL,
  output logic [3:0] SecH,
  output logic [3:0] MinL,
  output logic [3:0] MinH,
  output logic [3:0] HourL,
  output logic [3:0] HourH,
  output logic [3:0] Week,
  output logic       AdjtWeek,
  output logic [1:0] AdjField
);

  logic modeEv, incEv;
  AdjState_t state, nextState;
  logic [7:0] sec, min, hour;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKeyMode (
    .CLK(CLK), .RSTn(RSTn), .KeyRaw_n(KeyMode_n), .Press(modeEv)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uKeyInc (
    .CLK(CLK), .RSTn(RSTn), .KeyRaw_n(KeyInc_n), .Press(incEv)
  );

  always_comb begin
    nextState = state;
    if (modeEv) begin
      case (state)
        RUN:      nextState = ADJ_HOUR;
        ADJ_HOUR: nextState = ADJ_MIN;
        ADJ_MIN:  nextState = ADJ_WEEK;
        default:  nextState = RUN;
      endcase
    end
  end

  // AdjField/AdjtWeek are registered copies of the state and double as its debug view.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RUN;
      AdjField <= FIELD_NONE;
      AdjtWeek <= 1'b0;
    end else begin
      state    <= nextState;
      AdjField <= fieldOf(nextState);
      AdjtWeek <= (nextState == ADJ_WEEK);
    end
  end

  // Ticks count only in RUN; an inc coinciding with a mode event is dropped.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sec  <= 8'h00;
      min  <= 8'h00;
      hour <= 8'h00;
      Week <= WEEK_MIN;
    end else if (state == RUN && Tick1Hz) begin
      sec <= bcdInc(sec, SEC_MAX);
      if (sec == SEC_MAX) begin
        min <= bcdInc(min, MIN_MAX);
        if (min == MIN_MAX) begin
          hour <= bcdInc(hour, HOUR_MAX);
          if (hour == HOUR_MAX)
            Week <= weekInc(Week);
        end
      end
    end else if (incEv && !modeEv) begin
      case (state)
        ADJ_HOUR: hour <= bcdInc(hour, HOUR_MAX);
        ADJ_MIN: begin
          min <= bcdInc(min, MIN_MAX);
          sec <= 8'h00;
        end
        ADJ_WEEK: Week <= weekInc(Week);
        default: ;
      endcase
    end
  end

  assign SecL  = sec[3:0];
  assign SecH  = sec[7:4];
  assign MinL  = min[3:0];
  assign MinH  = min[7:4];
  assign HourL = hour[3:0];
  assign HourH = hour[7:4];

endmodule

// File: tb/tb_clock_adjust_ctrl.sv
// Bench for clock_adjust_ctrl: seconds-of-day reference model, per-cycle output
// compare, directed adjust scenarios with literal checkpoints and a random phase.
module tb_clock_adjust_ctrl;

  localparam int W = 31;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic Tick1Hz = 1'b0;
  logic KeyMode_n = 1'b1;
  logic KeyInc_n = 1'b1;
  logic [3:0] SecL, SecH, MinL, MinH, HourL, HourH, Week;
  logic AdjtWeek;
  logic [1:0] AdjField;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  clock_adjust_ctrl #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .CLK(CLK), .RSTn(RSTn), .Tick1Hz(Tick1Hz),
    .KeyMode_n(KeyMode_n), .KeyInc_n(KeyInc_n),
    .SecL(SecL), .SecH(SecH), .MinL(MinL), .MinH(MinH),
    .HourL(HourL), .HourH(HourH), .Week(Week),
    .AdjtWeek(AdjtWeek), .AdjField(AdjField)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // reference model: time as seconds of day, state as 0..3 (0 = run)
  int mSec = 0;
  int mWeek = 1;
  int mState = 0;
  bit mLevel[2];
  bit hist[2][6];
  bit pend[2];
  bit raw[2];
  bit modeE, incE;

  function automatic logic [W-1:0] expVec();
    int h, mi, s;
    h = mSec / 3600;
    mi = (mSec / 60) % 60;
    s = mSec % 60;
    return {4'(s % 10), 4'(s / 10), 4'(mi % 10), 4'(mi / 10), 4'(h % 10), 4'(h / 10),
            4'(mWeek), (mState == 3), 2'(mState)};
  endfunction

  task automatic modelReset();
    mSec = 0;
    mWeek = 1;
    mState = 0;
    for (int k = 0; k < 2; k++) begin
      mLevel[k] = 1'b1;
      pend[k] = 1'b0;
      for (int j = 0; j < 6; j++) hist[k][j] = 1'b1;
    end
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      modelReset();
      exp_q.delete();
      exp_q.push_back(expVec());
    end else begin
      modeE = pend[0];
      incE = pend[1];
      raw[0] = KeyMode_n;
      raw[1] = KeyInc_n;
      if (mState == 0 && Tick1Hz) begin
        mSec = mSec + 1;
        if (mSec == 86400) begin
          mSec = 0;
          mWeek = mWeek % 7 + 1;
        end
      end else if (incE && !modeE) begin
        case (mState)
          1: mSec = ((mSec / 3600 + 1) % 24) * 3600 + mSec % 3600;
          2: mSec = (mSec / 3600) * 3600 + (((mSec / 60) % 60 + 1) % 60) * 60;
          3: mWeek = mWeek % 7 + 1;
          default: ;
        endcase
      end
      if (modeE) mState = (mState + 1) % 4;
      // a key level flips once its synchronized samples disagree 4 cycles running
      for (int k = 0; k < 2; k++) begin
        for (int j = 5; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = raw[k];
        pend[k] = 1'b0;
        if (hist[k][2] != mLevel[k] && hist[k][3] != mLevel[k] &&
            hist[k][4] != mLevel[k] && hist[k][5] != mLevel[k]) begin
          mLevel[k] = !mLevel[k];
          pend[k] = !mLevel[k];
        end
      end
      exp_q.push_back(expVec());
    end
  end

  // scoreboard: compare every cycle against the latest model expectation
  logic [W-1:0] gotVec, expected;
  assign gotVec = {SecL, SecH, MinL, MinH, HourL, HourH, Week, AdjtWeek, AdjField};

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      expected = exp_q[$];
      exp_q.delete();
      checks++;
      if (gotVec !== expected) begin
        errors++;
        if (errors <= 20)
          $display("FAIL outputs t=%0t got %h expected %h", $time, gotVec, expected);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic tickN(input int n);
    repeat (n) begin
      Tick1Hz = 1'b1;
      step(1);
      Tick1Hz = 1'b0;
      step(1);
    end
  endtask

  task automatic press(input bit mode, input bit inc);
    if (mode) KeyMode_n = 1'b0;
    if (inc) KeyInc_n = 1'b0;
    step(8);
    KeyMode_n = 1'b1;
    KeyInc_n = 1'b1;
    step(8);
  endtask

  task automatic pressN(input bit mode, input bit inc, input int n);
    repeat (n) press(mode, inc);
  endtask

  // literal checkpoint: hhmmss as 24-bit BCD
  task automatic checkLit(input string name, input logic [23:0] hms, input logic [3:0] wk,
                          input logic adjt, input logic [1:0] fld);
    logic [30:0] got, want;
    @(negedge CLK);
    #1;
    got = {HourH, HourL, MinH, MinL, SecH, SecL, Week, AdjtWeek, AdjField};
    want = {hms, wk, adjt, fld};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  int modeHold, incHold;

  initial begin
    step(3);
    checkLit("reset_values", 24'h000000, 4'd1, 1'b0, 2'd0);
    RSTn = 1'b1;
    step(2);

    tickN(7177);
    checkLit("run_01_59_37", 24'h015937, 4'd1, 1'b0, 2'd0);

    KeyMode_n = 1'b0; step(1);
    KeyMode_n = 1'b1; step(1);
    KeyMode_n = 1'b0; step(3);
    KeyMode_n = 1'b1; step(10);
    checkLit("bounce_no_event", 24'h015937, 4'd1, 1'b0, 2'd0);

    KeyMode_n = 1'b0; step(10);
    KeyMode_n = 1'b1; step(8);
    checkLit("mode_held_adj_hour", 24'h015937, 4'd1, 1'b0, 2'd1);

    pressN(1'b0, 1'b1, 22);
    checkLit("adj_hour_23", 24'h235937, 4'd1, 1'b0, 2'd1);
    press(1'b0, 1'b1);
    checkLit("adj_hour_wrap", 24'h005937, 4'd1, 1'b0, 2'd1);
    pressN(1'b0, 1'b1, 12);
    press(1'b1, 1'b1);
    checkLit("coincident_mode_inc", 24'h125937, 4'd1, 1'b0, 2'd2);
    press(1'b0, 1'b1);
    checkLit("adj_min_inc", 24'h120000, 4'd1, 1'b0, 2'd2);
    tickN(10);
    checkLit("adj_min_frozen", 24'h120000, 4'd1, 1'b0, 2'd2);

    press(1'b1, 1'b0);
    pressN(1'b0, 1'b1, 6);
    checkLit("adj_week_7", 24'h120000, 4'd7, 1'b1, 2'd3);
    press(1'b0, 1'b1);
    checkLit("adj_week_wrap", 24'h120000, 4'd1, 1'b1, 2'd3);
    press(1'b1, 1'b0);
    checkLit("back_to_run", 24'h120000, 4'd1, 1'b0, 2'd0);

    press(1'b1, 1'b0);
    pressN(1'b0, 1'b1, 11);
    press(1'b1, 1'b0);
    pressN(1'b0, 1'b1, 59);
    press(1'b1, 1'b0);
    pressN(1'b0, 1'b1, 6);
    press(1'b1, 1'b0);
    tickN(59);
    checkLit("preset_23_59_59", 24'h235959, 4'd7, 1'b0, 2'd0);
    Tick1Hz = 1'b1;
    step(1);
    Tick1Hz = 1'b0;
    checkLit("midnight_rollover", 24'h000000, 4'd1, 1'b0, 2'd0);

    modeHold = 0;
    incHold = 0;
    for (int i = 0; i < 4000; i++) begin
      Tick1Hz = ($urandom_range(0, 3) == 0);
      if (modeHold == 0) begin
        KeyMode_n = 1'($urandom_range(0, 1));
        modeHold = $urandom_range(1, 12);
      end
      if (incHold == 0) begin
        KeyInc_n = 1'($urandom_range(0, 1));
        incHold = $urandom_range(1, 12);
      end
      modeHold--;
      incHold--;
      step(1);
    end
    Tick1Hz = 1'b0;
    KeyMode_n = 1'b1;
    KeyInc_n = 1'b1;
    step(12);

    if (AdjField == 2'd0) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    RSTn = 1'b0;
    checkLit("reset_mid_adjust", 24'h000000, 4'd1, 1'b0, 2'd0);
    step(2);
    RSTn = 1'b1;
    step(2);
    Tick1Hz = 1'b1;
    step(1);
    Tick1Hz = 1'b0;
    checkLit("tick_after_reset", 24'h000001, 4'd1, 1'b0, 2'd0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
